// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl
// Front-end control for the 8-bit running-light pattern generator.
// Synchronises and debounces three active-low push-buttons, holds the display
// mode (OFF/A/B/C), the speed index and the run/pause flag, and produces a
// one-cycle step strobe at STEP_DIV >> speed cycles per step.

module led_mode_ctrl #(
    parameter int DEB_CNT  = 1_000_000,
    parameter int STEP_DIV = 2_500_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       res,
    input  logic [2:0] key_n,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       step,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       run
);

    typedef enum logic [1:0] {
        M_OFF = 2'd0,
        M_A   = 2'd1,
        M_B   = 2'd2,
        M_C   = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] STEP_BASE = CNT_W'(STEP_DIV);

    // key synchroniser stages
    logic [2:0]       s1;
    logic [2:0]       s2;

    // debounce state: accepted level, stability counter and press pulse per key
    logic [2:0]       acc;
    logic [2:0]       ev;
    logic [CNT_W-1:0] deb_cnt [3];

    mode_t            state;

    // step divider
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] period;
    logic             any_ev;

    // two-flop synchroniser, released (1) level out of reset
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    // per-key debounce; a press pulse fires only on the accepted 1->0 transition
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            acc <= '1;
            ev  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                ev[i] <= 1'b0;
                if (s2[i] == acc[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    acc[i]     <= s2[i];
                    deb_cnt[i] <= '0;
                    // acc was 1 here means the new level is 0: a press
                    ev[i]      <= acc[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // mode FSM with registered one-hot selects, advanced by key0 presses
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= M_OFF;
            a     <= 1'b0;
            b     <= 1'b0;
            c     <= 1'b0;
        end else if (ev[0]) begin
            case (state)
                M_OFF: begin
                    state <= M_A;
                    a     <= 1'b1;
                    b     <= 1'b0;
                    c     <= 1'b0;
                end
                M_A: begin
                    state <= M_B;
                    a     <= 1'b0;
                    b     <= 1'b1;
                    c     <= 1'b0;
                end
                M_B: begin
                    state <= M_C;
                    a     <= 1'b0;
                    b     <= 1'b0;
                    c     <= 1'b1;
                end
                default: begin
                    state <= M_OFF;
                    a     <= 1'b0;
                    b     <= 1'b0;
                    c     <= 1'b0;
                end
            endcase
        end
    end

    assign mode = state;

    // speed index (key1, wraps 3->0) and run/pause toggle (key2)
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            speed <= 2'd0;
            run   <= 1'b1;
        end else begin
            if (ev[1]) begin
                speed <= speed + 2'd1;
            end
            if (ev[2]) begin
                run <= ~run;
            end
        end
    end

    // current step period for the registered speed index
    always_comb begin
        period = STEP_BASE >> speed;
    end

    assign any_ev = |ev;

    // step divider; any key event restarts the period and beats a coincident terminal count
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            div_cnt <= '0;
            step    <= 1'b0;
        end else begin
            step <= 1'b0;
            // run toggles also restart: pausing holds 0 anyway and resuming carries nothing over
            if (any_ev || !run || (state == M_OFF)) begin
                div_cnt <= '0;
            end else if (div_cnt == period - 1'b1) begin
                div_cnt <= '0;
                step    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl
// Directed bench for led_mode_ctrl with DEB_CNT=4, STEP_DIV=16 on a 50 MHz clock.
// Inputs are driven and outputs sampled 1 ns after each rising edge.

module tb_led_mode_ctrl;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [2:0] key_n = 3'b111;
    logic       a;
    logic       b;
    logic       c;
    logic       step;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       run;

    int n_pass = 0;
    int n_chk  = 0;
    int cnt;

    led_mode_ctrl #(
        .DEB_CNT  (4),
        .STEP_DIV (16),
        .CNT_W    (26)
    ) dut (
        .clk   (clk),
        .res   (res),
        .key_n (key_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .step  (step),
        .mode  (mode),
        .speed (speed),
        .run   (run)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // clean press: low long enough for one event, then released long enough to settle
    task automatic press(input int k);
        key_n[k] = 1'b0;
        repeat (8) tick();
        key_n[k] = 1'b1;
        repeat (8) tick();
    endtask

    // cycles until the next step strobe, bounded
    task automatic wait_step(input string tag, input int exp);
        int n = 0;
        do begin
            tick();
            n++;
        end while (step !== 1'b1 && n < 200);
        check(tag, n, exp);
    endtask

    // align to a step strobe, bounded
    task automatic sync_step(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (step !== 1'b1 && n < 200);
        check(tag, step, 1);
    endtask

    task automatic count_steps(input int cycles, output int nst);
        nst = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (step === 1'b1) nst++;
        end
    endtask

    initial begin
        // reset values
        repeat (3) tick();
        check("rst_abc", {a, b, c}, 3'b000);
        check("rst_step", step, 0);
        check("rst_mode", mode, 0);
        check("rst_speed", speed, 0);
        check("rst_run", run, 1);
        res = 1'b0;
        tick();

        // debounce: short bounces ignored
        for (int r = 0; r < 5; r++) begin
            key_n[0] = 1'b0;
            repeat (3) tick();
            key_n[0] = 1'b1;
            repeat (3) tick();
        end
        repeat (6) tick();
        check("bounce_mode", mode, 0);

        // clean hold: a rises 7 cycles after the fall, single event
        key_n[0] = 1'b0;
        repeat (6) tick();
        check("deb_early_a", a, 0);
        tick();
        check("deb_a", a, 1);
        check("deb_mode", mode, 1);
        repeat (20) tick();
        check("hold_mode", mode, 1);
        key_n[0] = 1'b1;
        repeat (10) tick();
        check("release_mode", mode, 1);

        // mode wrap through B, C, OFF, A
        press(0);
        check("wrap_mode_b", mode, 2);
        check("wrap_abc_b", {a, b, c}, 3'b010);
        press(0);
        check("wrap_mode_c", mode, 3);
        check("wrap_abc_c", {a, b, c}, 3'b001);
        press(0);
        check("wrap_mode_off", mode, 0);
        check("wrap_abc_off", {a, b, c}, 3'b000);
        count_steps(40, cnt);
        check("off_no_step", cnt, 0);
        press(0);
        check("wrap_mode_a", mode, 1);
        check("wrap_abc_a", {a, b, c}, 3'b100);

        // speed: periods 16, 8, 4, 2 then back to 16
        sync_step("sync_s0");
        wait_step("period_s0", 16);
        tick();
        check("step_width", step, 0);
        press(1);
        check("speed1", speed, 1);
        sync_step("sync_s1");
        wait_step("period_s1", 8);
        press(1);
        check("speed2", speed, 2);
        sync_step("sync_s2");
        wait_step("period_s2", 4);
        press(1);
        check("speed3", speed, 3);
        sync_step("sync_s3");
        wait_step("period_s3", 2);
        key_n[1] = 1'b0;
        repeat (7) tick();
        check("speed_wrap", speed, 0);
        check("chg_no_step", step, 0);
        key_n[1] = 1'b1;
        wait_step("first_after_chg", 16);

        // pause in mode B at count 10, resume gives a full period
        press(0);
        check("pause_mode_b", mode, 2);
        sync_step("sync_pause");
        repeat (3) tick();
        key_n[2] = 1'b0;
        repeat (7) tick();
        check("paused_run", run, 0);
        key_n[2] = 1'b1;
        count_steps(100, cnt);
        check("paused_no_step", cnt, 0);
        key_n[2] = 1'b0;
        repeat (7) tick();
        check("resumed_run", run, 1);
        key_n[2] = 1'b1;
        wait_step("resume_period", 16);

        // key0 and key1 together, landing on the terminal count
        repeat (9) tick();
        key_n[1:0] = 2'b00;
        repeat (7) tick();
        check("simul_no_step", step, 0);
        check("simul_mode", mode, 3);
        check("simul_speed", speed, 1);
        key_n[1:0] = 2'b11;
        wait_step("simul_period", 8);

        // asynchronous reset mid-run
        repeat (3) tick();
        res = 1'b1;
        #1;
        check("arst_abc", {a, b, c}, 3'b000);
        check("arst_step", step, 0);
        check("arst_mode", mode, 0);
        check("arst_speed", speed, 0);
        check("arst_run", run, 1);
        repeat (3) tick();
        res = 1'b0;
        count_steps(45, cnt);
        check("arst_no_step", cnt, 0);
        check("arst_mode_hold", mode, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
